fwd_hazard_ctrl: RTL

// Parametrised forwarding/hazard controller for the redirect pipeline; successor of the combinational bypass-select logic.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 19 +
 rtl/fwd_match_prio.sv | 57 +++++
 rtl/fwd_hazard_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller.
//   sel_w()      : width of one per-operand bypass select for a given tracking depth
//   SEL_RF       : select encoding meaning "take the operand from the register file"
//   fsm_state_t  : load-use stall FSM states
package fwd_hazard_ctrl_pkg;

  // One select must encode 0 (regfile) plus one code per tracked entry.
  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int SEL_RF = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fwd_match_prio.sv
// Per-operand dependency check against the in-flight destination tracker.
// Compares one source register against every tracked entry, picks the youngest
// producer and reports whether that producer is a load whose data is not yet
// bypassable.
//   i_src        : source register index of this operand
//   i_used       : operand is actually read by a valid ID instruction
//   i_ent_valid  : per-entry valid, entry 0 (EX) at bit 0
//   i_ent_dst    : per-entry destination, entry k at [k*REGW +: REGW]
//   i_ent_load   : per-entry "producer is a load"
//   o_sel        : bypass select, 0 = regfile, k+1 = producer at entry k
//   o_hazard     : youngest producer is a load still inside the load shadow
//   o_need       : stall cycles needed before the load result is bypassable
module fwd_match_prio
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REGW    = 5,
  parameter int DEPTH   = 2,
  parameter int LOADLAT = 1,
  parameter int SELW    = sel_w(DEPTH)
) (
  input  logic [REGW-1:0]       i_src,
  input  logic                  i_used,
  input  logic [DEPTH-1:0]      i_ent_valid,
  input  logic [DEPTH*REGW-1:0] i_ent_dst,
  input  logic [DEPTH-1:0]      i_ent_load,
  output logic [SELW-1:0]       o_sel,
  output logic                  o_hazard,
  output logic [SELW-1:0]       o_need
);

  logic             w_src_ok;
  logic [DEPTH-1:0] w_hit;

  // Register 0 is hardwired zero and never takes a bypass.
  assign w_src_ok = i_used && (i_src != '0);

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign w_hit[gi] = w_src_ok && i_ent_valid[gi] &&
                       (i_ent_dst[gi*REGW +: REGW] == i_src);
  end

  // Scan oldest to youngest so the youngest hit overwrites the rest.
  always_comb begin
    o_sel    = SELW'(SEL_RF);
    o_hazard = 1'b0;
    o_need   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_sel    = SELW'(k + 1);
        o_hazard = i_ent_load[k] && (k < LOADLAT);
        o_need   = (i_ent_load[k] && (k < LOADLAT)) ? SELW'(LOADLAT - k) : '0;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard controller between decode (ID) and the EX operand muxes.
// Tracks in-flight destinations in a shift register, registers per-operand
// bypass selects aligned to EX, stalls ID on load-use (multi-cycle for deep
// load latency), flushes IF/ID on an EX redirect and counts events.
//   clk, rst     : clock, synchronous active-high reset
//   id_valid     : valid instruction in ID
//   id_src       : source indices, operand i at [i*REGW +: REGW]
//   id_src_used  : operand i is read
//   id_dst/id_wen: destination register and write enable
//   id_is_load   : ID instruction is a load
//   ex_redirect  : taken branch/jump resolved in EX
//   stall, flush : combinational pipeline controls
//   fwd_sel      : registered selects, 0 = regfile, k = result of entry k-1
//   *_cnt        : saturating event counters
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NSRC    = 2,
  parameter int REGW    = 5,
  parameter int DEPTH   = 2,
  parameter int LOADLAT = 1,
  parameter int CNTW    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [NSRC*REGW-1:0]           id_src,
  input  logic [NSRC-1:0]                id_src_used,
  input  logic [REGW-1:0]                id_dst,
  input  logic                           id_wen,
  input  logic                           id_is_load,
  input  logic                           ex_redirect,
  output logic                           stall,
  output logic                           flush,
  output logic [NSRC*sel_w(DEPTH)-1:0]   fwd_sel,
  output logic [CNTW-1:0]                stall_cnt,
  output logic [CNTW-1:0]                fwd_cnt,
  output logic [CNTW-1:0]                flush_cnt
);

  localparam int SELW = sel_w(DEPTH);

  // Tracker: entry 0 (EX) at the low end, oldest at the high end.
  logic [DEPTH-1:0]      r_ent_valid;
  logic [DEPTH*REGW-1:0] r_ent_dst;
  logic [DEPTH-1:0]      r_ent_load;
  fsm_state_t            r_state;
  logic [SELW-1:0]       r_wait;
  logic [NSRC*SELW-1:0]  r_fwd_sel;
  logic [CNTW-1:0]       r_stall_cnt;
  logic [CNTW-1:0]       r_fwd_cnt;
  logic [CNTW-1:0]       r_flush_cnt;

  logic [NSRC*SELW-1:0]  w_sel;
  logic [NSRC*SELW-1:0]  w_sel_next;
  logic [NSRC-1:0]       w_haz;
  logic [SELW-1:0]       w_need [NSRC];
  logic                  w_any_haz;
  logic [SELW-1:0]       w_need_max;
  fsm_state_t            w_state_next;
  logic [SELW-1:0]       w_wait_next;
  logic                  w_stall_req;
  logic                  w_stall;
  logic                  w_flush;
  logic                  w_adv;
  logic                  w_push;
  logic [CNTW-1:0]       w_pop;
  logic [CNTW:0]         w_fwd_sum;

  genvar gi;
  for (gi = 0; gi < NSRC; gi++) begin : g_op
    fwd_match_prio #(
      .REGW    (REGW),
      .DEPTH   (DEPTH),
      .LOADLAT (LOADLAT),
      .SELW    (SELW)
    ) u_match (
      .i_src       (id_src[gi*REGW +: REGW]),
      .i_used      (id_src_used[gi] & id_valid),
      .i_ent_valid (r_ent_valid),
      .i_ent_dst   (r_ent_dst),
      .i_ent_load  (r_ent_load),
      .o_sel       (w_sel[gi*SELW +: SELW]),
      .o_hazard    (w_haz[gi]),
      .o_need      (w_need[gi])
    );
  end

  // The longest-waiting operand decides how long ID is held.
  always_comb begin
    w_any_haz  = 1'b0;
    w_need_max = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_haz[i]) begin
        w_any_haz = 1'b1;
        if (w_need[i] > w_need_max) w_need_max = w_need[i];
      end
    end
  end

  // Redirect wins over any stall: the stalled instruction is being killed.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_stall_req  = 1'b0;
    if (ex_redirect) begin
      w_state_next = IDLE;
      w_wait_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_haz) begin
            w_stall_req = 1'b1;
            w_wait_next = w_need_max - SELW'(1);
            if (w_wait_next != '0) w_state_next = STALL;
          end
        end
        STALL: begin
          w_stall_req = 1'b1;
          w_wait_next = r_wait - SELW'(1);
          if (w_wait_next == '0) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_flush    = ex_redirect && !rst;
  assign w_stall    = w_stall_req && !ex_redirect && !rst;
  assign w_adv      = id_valid && !w_stall && !w_flush;
  assign w_push     = w_adv && id_wen;
  assign w_sel_next = w_adv ? w_sel : '0;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_sel_next[i*SELW +: SELW] != '0) w_pop = w_pop + CNTW'(1);
    end
  end

  assign w_fwd_sum = {1'b0, r_fwd_cnt} + {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent_valid <= '0;
      r_ent_dst   <= '0;
      r_ent_load  <= '0;
      r_state     <= IDLE;
      r_wait      <= '0;
      r_fwd_sel   <= '0;
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_ent_valid <= {r_ent_valid[DEPTH-2:0], w_push};
      r_ent_dst   <= {r_ent_dst[(DEPTH-1)*REGW-1:0], id_dst};
      r_ent_load  <= {r_ent_load[DEPTH-2:0], w_push & id_is_load};
      r_state     <= w_state_next;
      r_wait      <= w_wait_next;
      r_fwd_sel   <= w_sel_next;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNTW'(1);
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNTW'(1);
      r_fwd_cnt <= w_fwd_sum[CNTW] ? '1 : w_fwd_sum[CNTW-1:0];
    end
  end

  assign stall     = w_stall;
  assign flush     = w_flush;
  assign fwd_sel   = r_fwd_sel;
  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
